mem_access: RTL and testbench
=============================

# mem_access

Data-memory responder for the execute stage's load/store interface. Accepts one load or store per request, using the ALU result as the byte address and rs2 as the store data. Performs the access as a sequence of byte transfers on a byte-wide, ack-handshaked memory bus. For loads, returns the data big-endian packed in `memData`: byte at addr in [31:24], unused low bytes zero, so execute's LB/LH/LW/LBU/LHU selection and extension work unchanged.

## Interface
- XLEN, 32, datapath width of request address/data and `memData`
- ADDR_W, 16, byte-address width of the memory bus (request address truncated to it)

- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- req_valid  input  1  load/store request present; held stable by pipeline while `stall`=1
- req_store  input  1  1 = store, 0 = load
- req_size  input  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word
- req_addr  input  XLEN  byte address (ALU result)
- req_wdata  input  XLEN  store data (rs2)
- stall  output  1  freeze pipeline while request is in flight
- memData  output  32  load result, big-endian packed, held until next load completes
- data_valid  output  1  one-cycle pulse when load/store completes
- mem_req  output  1  byte transfer request
- mem_we  output  1  1 = byte write
- mem_addr  output  ADDR_W  byte address of current transfer
- mem_wdata  output  8  write byte
- mem_rdata  input  8  read byte, valid when mem_ack=1
- mem_ack  input  1  transfer complete this cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if req_valid, latch store/size/addr/wdata and set byte count n (1/2/4) and index k=0. Go to ACCESS.
- ACCESS: mem_req=1, mem_we=req_store latched, mem_addr=(addr+k) mod 2^ADDR_W.
  - Store byte k: half = wdata[15:8], wdata[7:0]; word = wdata[31:24] down to [7:0]; byte = wdata[7:0].
  - On mem_ack: for loads, capture mem_rdata into shift buffer lane k (lane 0 = [31:24]); k++.
  - When k reaches n-1 and ack: go to DONE.
- DONE: data_valid=1. For loads, `memData` = buffer with lanes ≥n zero. For stores, `memData` is unchanged. Go to IDLE.
- stall = (IDLE & req_valid) | ACCESS; 0 in DONE, so the pipeline advances on the DONE→IDLE edge and the same request is not re-accepted.
- Misaligned addresses allowed, no trap; address wraps at 2^ADDR_W.
- mem_ack while mem_req=0 ignored. mem_rdata ignored for stores.

## Timing
- Reset: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, memData=0, data_valid=0, stall=req_valid (combinational).
- Zero-wait memory (ack every cycle), request seen at edge T: ACCESS cycles T+1..T+n, DONE at T+n+1, data_valid at T+n+1. Word load = 5 cycles after acceptance; byte = 2.
- Each wait cycle (mem_req=1, mem_ack=0) extends ACCESS by one cycle. mem_addr/mem_we/mem_wdata are held stable while waiting.
- All bus outputs are registered or decoded from registered state, never from req_* inputs.
- Reset asserted mid-access: immediate abort, mem_req drops asynchronously, partial load bytes discarded, memData cleared. No completion pulse.

## Structure
- Shared package `fewcore_mem_pkg`: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), state enum, byte-count function size→n.
- Single module; no sub-module needed (lane select/packing is a small case inside).

## Test plan
- LW addr 0x0100, memory bytes 11,22,33,44, ack every cycle → mem_addr 0x100..0x103 on cycles T+1..T+4, memData=0x11223344, data_valid at T+5, stall high T..T+4.
- LB addr 0x0007, byte 0x80 → memData=0x80000000 (execute sign-extends to 0xFFFFFF80); LH addr 0x0002, bytes A5,5A → memData=0xA55A0000.
- SW addr 0x0010 data 0xDEADBEEF → writes DE,AD,BE,EF to 0x10..0x13, mem_we=1, memData unchanged; SH data 0x1234ABCD at 0x20 → AB@0x20, CD@0x21.
- LW with 2 wait cycles per byte → mem_addr/mem_we held during waits, data_valid at T+13, result correct.
- LW at 0xFFFE (ADDR_W=16) → addresses FFFE, FFFF, 0000, 0001 (wrap).
- reset low during byte 2 of LW → mem_req=0 same cycle, memData=0, no data_valid. After release, new LB completes normally.

Source files
------------

// File: rtl/fewcore_mem_pkg.sv
// ---------------------------------------------------------------------------
// fewcore_mem_pkg
// Shared definitions for the data-memory responder (mem_access).
//   - Default datapath / memory-bus address widths
//   - Access size encodings (funct3[1:0])
//   - Responder state enum
//   - Helpers: byte count per size, store-byte lane selection,
//     load-result lane mask
// ---------------------------------------------------------------------------
package fewcore_mem_pkg;

  localparam int MEM_XLEN   = 32;
  localparam int MEM_ADDR_W = 16;

  // Access size encodings taken from funct3[1:0]; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of byte transfers needed for an access of the given size.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Byte k of an n-byte store. The n low bytes of the store data go out
  // most-significant first, so byte 0 of a word is data[31:24] and byte 0
  // of a half is data[15:8].
  function automatic logic [7:0] store_byte(input logic [31:0] data,
                                            input logic [2:0]  n,
                                            input logic [1:0]  k);
    logic [7:0] b;
    b = data[7:0];
    case (n)
      3'd2: b = (k == 2'd0) ? data[15:8] : data[7:0];
      3'd4: begin
        case (k)
          2'd0:    b = data[31:24];
          2'd1:    b = data[23:16];
          2'd2:    b = data[15:8];
          default: b = data[7:0];
        endcase
      end
      default: b = data[7:0];
    endcase
    return b;
  endfunction

  // Keeps the lanes that belong to an n-byte load (lane 0 = [31:24]).
  function automatic logic [31:0] lane_mask(input logic [2:0] n);
    logic [31:0] m;
    case (n)
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Data-memory responder for the execute stage's load/store interface.
// Each accepted request is carried out as 1, 2 or 4 byte transfers on a
// byte-wide, ack-handshaked memory bus. Load results are returned packed
// big-endian in memData (first byte in [31:24], unused low bytes zero).
//
// Ports
//   clk         core clock, rising edge
//   reset       asynchronous, active-low reset (0 = reset)
//   req_valid   load/store request present (held while stall=1)
//   req_store   1 = store, 0 = load
//   req_size    00 byte, 01 half, 10/11 word
//   req_addr    byte address (truncated to ADDR_W on the bus)
//   req_wdata   store data
//   stall       freeze pipeline while a request is in flight
//   memData     last load result, held until the next load completes
//   data_valid  one-cycle pulse when an access completes
//   mem_req     byte transfer request
//   mem_we      1 = byte write
//   mem_addr    byte address of the current transfer
//   mem_wdata   write byte
//   mem_rdata   read byte, valid with mem_ack
//   mem_ack     transfer completes this cycle
// ---------------------------------------------------------------------------
module mem_access
  import fewcore_mem_pkg::*;
#(
  parameter int XLEN   = MEM_XLEN,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic [31:0]       memData,
  output logic              data_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  state_t          state;
  logic            is_store;
  logic [2:0]      count;
  logic [1:0]      idx;
  logic [XLEN-1:0] wdata_q;
  logic [31:0]     load_buf;
  logic [31:0]     captured;
  logic            last;
  logic            addr_unused;

  // Address bits above the bus width are dropped on purpose.
  assign addr_unused = ^req_addr[XLEN-1:ADDR_W];

  // The request is held by the pipeline until DONE, so stall must not be
  // asserted in DONE or the same request would be accepted a second time.
  assign stall = ((state == IDLE) && req_valid) || (state == ACCESS);

  assign last = ({1'b0, idx} == (count - 3'd1));

  // Load buffer with the byte arriving this cycle dropped into lane idx.
  always_comb begin
    captured = load_buf;
    case (idx)
      2'd0:    captured[31:24] = mem_rdata;
      2'd1:    captured[23:16] = mem_rdata;
      2'd2:    captured[15:8]  = mem_rdata;
      default: captured[7:0]   = mem_rdata;
    endcase
  end

  // Main FSM. Bus outputs are registered so they never follow req_*
  // combinationally; they stay put while the memory is not acking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      is_store   <= 1'b0;
      count      <= 3'd0;
      idx        <= 2'd0;
      wdata_q    <= '0;
      load_buf   <= '0;
      memData    <= '0;
      data_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store  <= req_store;
            count     <= byte_count(req_size);
            idx       <= 2'd0;
            wdata_q   <= req_wdata;
            load_buf  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= req_store;
            mem_addr  <= req_addr[ADDR_W-1:0];
            mem_wdata <= store_byte(req_wdata[31:0], byte_count(req_size), 2'd0);
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            if (!is_store) begin
              load_buf <= captured;
            end
            if (last) begin
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_wdata  <= '0;
              data_valid <= 1'b1;
              if (!is_store) begin
                memData <= captured & lane_mask(count);
              end
              state <= DONE;
            end else begin
              idx       <= idx + 2'd1;
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= store_byte(wdata_q[31:0], count, idx + 2'd1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access. A byte-array memory responds on the
// bus with configurable or random wait states; each request's expected
// transfers, latency and load result are computed from the byte array.
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] memData;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  tb_mem [0:65535];
  logic [31:0] model_mem_data;

  int wait_cycles  = 0;
  bit rand_wait    = 0;
  bit spurious_ack = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t log_q[$];

  mem_access #(.XLEN(32), .ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .memData    (memData),
    .data_valid (data_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory responder: decides on each falling edge whether the next rising
  // edge carries an ack, and logs every completed transfer.
  int          wcnt = 0;
  int          target = 0;
  bit          have_target = 0;
  logic [24:0] held;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || mem_req !== 1'b1) begin
        mem_ack     = spurious_ack ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata   = 8'($urandom);
        wcnt        = 0;
        have_target = 0;
      end else begin
        if (!have_target) begin
          target      = rand_wait ? int'($urandom_range(0, 2)) : wait_cycles;
          have_target = 1;
          held        = {mem_we, mem_addr, mem_wdata};
        end else begin
          tests_run++;
          if ({mem_we, mem_addr, mem_wdata} !== held) begin
            tests_failed++;
            $display("[TB] FAIL bus_hold: got %h, required %h", {mem_we, mem_addr, mem_wdata}, held);
          end
        end
        if (wcnt < target) begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          wcnt++;
        end else begin
          mem_ack = 1'b1;
          log_q.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
          if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            mem_rdata = tb_mem[mem_addr];
          end
          wcnt        = 0;
          have_target = 0;
        end
      end
    end
  end

  // Issue one request and check latency, stall, bus transfers and result.
  // exp_cycles < 0 skips the latency check. after_done: called in the DONE
  // cycle of a previous request. chain_next: leave req_valid high at DONE.
  task automatic do_req(input bit store, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_cycles, input bit after_done,
                        input bit chain_next, input string name);
    int          n;
    int          cycles;
    bit          seen;
    bit          stall_ok;
    logic [31:0] exp_data;
    logic [15:0] a;
    logic [7:0]  exp_byte;

    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_data = 32'h0;
    if (!store) begin
      for (int i = 0; i < n; i++) begin
        a = addr[15:0] + 16'(i);
        exp_data[31-8*i -: 8] = tb_mem[a];
      end
    end
    log_q.delete();

    req_valid = 1'b1;
    req_store = store;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    stall_ok  = 1'b1;

    if (after_done) begin
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s done_stall: got %b, required 0", name, stall);
      end
      @(posedge clk);
      @(negedge clk);
    end

    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    @(posedge clk);

    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (data_valid === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end

    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: no data_valid within %0d cycles", name, cycles);
    end else begin
      if (exp_cycles >= 0) begin
        tests_run++;
        if (cycles != exp_cycles) begin
          tests_failed++;
          $display("[TB] FAIL %s latency: got %0d, required %0d", name, cycles, exp_cycles);
        end
      end

      tests_run++;
      if (!stall_ok || stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s stall: stall high during access %b, stall at done %b (required 1/0)",
                 name, stall_ok, stall);
      end

      tests_run++;
      if (log_q.size() != n) begin
        tests_failed++;
        $display("[TB] FAIL %s xfer_count: got %0d, required %0d", name, log_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          a        = addr[15:0] + 16'(i);
          exp_byte = wdata[8*(n-1-i) +: 8];
          tests_run++;
          if (log_q[i].we !== store || log_q[i].addr !== a ||
              (store && log_q[i].data !== exp_byte)) begin
            tests_failed++;
            $display("[TB] FAIL %s xfer%0d: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     name, i, log_q[i].we, log_q[i].addr, log_q[i].data,
                     store, a, store ? exp_byte : log_q[i].data);
          end
        end
      end
    end

    if (!store) model_mem_data = exp_data;
    if (seen) begin
      tests_run++;
      if (memData !== model_mem_data) begin
        tests_failed++;
        $display("[TB] FAIL %s memData: got %h, required %h", name, memData, model_mem_data);
      end
    end

    if (!chain_next) begin
      req_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (data_valid !== 1'b0 || stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s pulse: got data_valid=%b stall=%b, required 0/0", name, data_valid, stall);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 1'b1;
    #2;
    tests_run++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 8'h0 || memData !== 32'h0 || data_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got stall=%b req=%b we=%b addr=%h wd=%h md=%h dv=%b, required 1 0 0 0000 00 00000000 0",
               stall, mem_req, mem_we, mem_addr, mem_wdata, memData, data_valid);
    end
    req_valid = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stall: got %b, required 0", stall);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    tb_mem[16'h0100] = 8'h11;
    tb_mem[16'h0101] = 8'h22;
    tb_mem[16'h0102] = 8'h33;
    tb_mem[16'h0103] = 8'h44;
    do_req(1'b0, 2'b10, 32'h0000_0100, 32'h0, 5, 1'b0, 1'b0, "lw");
    tests_run++;
    if (model_mem_data !== 32'h1122_3344) begin
      tests_failed++;
      $display("[TB] FAIL lw_model: got %h, required 11223344", model_mem_data);
    end
  endtask

  task automatic test_load_byte_half();
    tb_mem[16'h0007] = 8'h80;
    do_req(1'b0, 2'b00, 32'h0000_0007, 32'h0, 2, 1'b0, 1'b0, "lb");
    tb_mem[16'h0002] = 8'hA5;
    tb_mem[16'h0003] = 8'h5A;
    do_req(1'b0, 2'b01, 32'h0000_0002, 32'h0, 3, 1'b0, 1'b0, "lh");
    do_req(1'b0, 2'b11, 32'h0000_0100, 32'h0, 5, 1'b0, 1'b0, "lw_size3");
  endtask

  task automatic test_store();
    do_req(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, "sw");
    do_req(1'b1, 2'b01, 32'h0000_0020, 32'h1234_ABCD, 3, 1'b0, 1'b0, "sh");
    do_req(1'b1, 2'b00, 32'h0000_0030, 32'h0000_0077, 2, 1'b0, 1'b0, "sb");
    do_req(1'b0, 2'b10, 32'h0000_0010, 32'h0, 5, 1'b0, 1'b0, "sw_readback");
    tests_run++;
    if (memData !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL sw_readback_value: got %h, required deadbeef", memData);
    end
    do_req(1'b0, 2'b01, 32'h0000_0020, 32'h0, 3, 1'b0, 1'b0, "sh_readback");
    tests_run++;
    if (memData !== 32'hABCD_0000) begin
      tests_failed++;
      $display("[TB] FAIL sh_readback_value: got %h, required abcd0000", memData);
    end
  endtask

  task automatic test_wait_states();
    wait_cycles = 2;
    do_req(1'b0, 2'b10, 32'h0000_0100, 32'h0, 13, 1'b0, 1'b0, "lw_wait");
    do_req(1'b1, 2'b01, 32'h0000_0040, 32'h0000_C3E1, 7, 1'b0, 1'b0, "sh_wait");
    wait_cycles = 0;
  endtask

  task automatic test_wrap();
    tb_mem[16'hFFFE] = 8'h9A;
    tb_mem[16'hFFFF] = 8'hBC;
    tb_mem[16'h0000] = 8'hDE;
    tb_mem[16'h0001] = 8'hF0;
    do_req(1'b0, 2'b10, 32'h0000_FFFE, 32'h0, 5, 1'b0, 1'b0, "lw_wrap");
    do_req(1'b0, 2'b10, 32'hABCD_FFFE, 32'h0, 5, 1'b0, 1'b0, "lw_wrap_hi");
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 2'b00, 32'h0000_0101, 32'h0, 2, 1'b0, 1'b1, "b2b_lb");
    do_req(1'b1, 2'b10, 32'h0000_0050, 32'h0102_0304, 5, 1'b1, 1'b1, "b2b_sw");
    do_req(1'b0, 2'b10, 32'h0000_0050, 32'h0, 5, 1'b1, 1'b0, "b2b_lw");
  endtask

  task automatic test_reset_abort();
    bit quiet;
    tb_mem[16'h0300] = 8'h31;
    tb_mem[16'h0301] = 8'h32;
    tb_mem[16'h0302] = 8'h33;
    tb_mem[16'h0303] = 8'h34;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0300;
    req_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || memData !== 32'h0 || data_valid !== 1'b0 || stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got req=%b md=%h dv=%b stall=%b, required 0 00000000 0 1",
               mem_req, memData, data_valid, stall);
    end
    model_mem_data = 32'h0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got activity after abort, required none");
    end
    do_req(1'b0, 2'b00, 32'h0000_0301, 32'h0, 2, 1'b0, 1'b0, "lb_after_abort");
  endtask

  task automatic test_random();
    rand_wait    = 1;
    spurious_ack = 1;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             -1, 1'b0, 1'b0, "rand");
    end
    rand_wait    = 0;
    spurious_ack = 0;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    model_mem_data = 32'h0;
    for (int i = 0; i < 65536; i++) tb_mem[i] = 8'($urandom);

    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store();
    test_wait_states();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
